// File: rtl/clock_sync_pkg.sv
// Shared types, default parameters and helpers for the multi-channel clock qualifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_sync_pkg;

    typedef enum logic [1:0] {CH_UNKNOWN, CH_LOW, CH_HIGH} ch_state_t;

    localparam int DEF_NUM_CH         = 2;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_HIGH_THRESHOLD = 4;
    localparam int DEF_LOW_THRESHOLD  = 4;
    localparam int DEF_FILT_W         = 5;
    localparam int DEF_IDLE_TIMEOUT   = 1000;
    localparam int DEF_CNT_W          = 8;

    // Width that can hold every value 0..timeout inclusive
    function automatic int idle_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/clock_sync_channel.sv
// One qualifier channel: synchroniser, glitch filter, level FSM, idle timer, rise counter.
// Latency: rise/fall pulse one cycle after the SYNC_STAGES+THRESHOLD-1'th edge of a stable input.
// Backpressure: none; free-running on every internal clock edge.
module clock_sync_channel
    import clock_sync_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int HIGH_THRESHOLD = DEF_HIGH_THRESHOLD,
    parameter int LOW_THRESHOLD  = DEF_LOW_THRESHOLD,
    parameter int FILT_W         = DEF_FILT_W,
    parameter int IDLE_TIMEOUT   = DEF_IDLE_TIMEOUT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             data_clk_i,
    output logic             rise_en_o,
    output logic             fall_en_o,
    output logic             level_o,
    output logic             clk_active_o,
    output logic [CNT_W-1:0] rise_count_o
);

    localparam int                IDLE_W = idle_cnt_w(IDLE_TIMEOUT);
    localparam logic [FILT_W-1:0] HI_T   = FILT_W'(HIGH_THRESHOLD);
    localparam logic [FILT_W-1:0] LO_T   = FILT_W'(LOW_THRESHOLD);
    localparam logic [IDLE_W-1:0] IDLE_T = IDLE_W'(IDLE_TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [FILT_W-1:0]      hi_cnt_q, hi_cnt_d;
    logic [FILT_W-1:0]      lo_cnt_q, lo_cnt_d;
    logic                   hi_hit, lo_hit;

    ch_state_t              state_q, state_d;

    logic                   rise_en_q, rise_en_d;
    logic                   fall_en_q, fall_en_d;
    logic                   level_q, level_d;
    logic                   active_q, active_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]       rise_cnt_q, rise_cnt_d;

    // Metastability chain; the last stage is the only use of the async input
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_clk_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Run-length counters of the synced level, saturating at their threshold
    always_comb begin
        hi_cnt_d = '0;
        lo_cnt_d = '0;
        if (enable_i) begin
            if (s) begin
                hi_cnt_d = (hi_cnt_q == HI_T) ? HI_T : hi_cnt_q + 1'b1;
            end else begin
                lo_cnt_d = (lo_cnt_q == LO_T) ? LO_T : lo_cnt_q + 1'b1;
            end
        end
    end

    // A hit fires only on the sample that brings the run up to its threshold,
    // so a long hold can never produce a second qualification
    assign hi_hit = enable_i &&  s && (hi_cnt_q == HI_T - 1'b1);
    assign lo_hit = enable_i && !s && (lo_cnt_q == LO_T - 1'b1);

    // Level state and filter counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= CH_UNKNOWN;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    // Next level state; disabling forgets the level entirely
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = CH_UNKNOWN;
        end else begin
            case (state_q)
                CH_UNKNOWN: begin
                    if (hi_hit) begin
                        state_d = CH_HIGH;
                    end else if (lo_hit) begin
                        state_d = CH_LOW;
                    end
                end
                CH_LOW:  if (hi_hit) state_d = CH_HIGH;
                CH_HIGH: if (lo_hit) state_d = CH_LOW;
                default: state_d = CH_UNKNOWN;
            endcase
        end
    end

    // Pulses, level, idle timer and rise counter derived from the state move
    always_comb begin
        rise_en_d  = (state_q == CH_LOW)  && (state_d == CH_HIGH);
        fall_en_d  = (state_q == CH_HIGH) && (state_d == CH_LOW);
        level_d    = (state_d == CH_HIGH);
        rise_cnt_d = rise_cnt_q + {{(CNT_W-1){1'b0}}, rise_en_d};
        idle_cnt_d = '0;
        active_d   = 1'b0;
        if (enable_i) begin
            if (rise_en_d || fall_en_d) begin
                idle_cnt_d = '0;
                active_d   = 1'b1;
            end else begin
                idle_cnt_d = (idle_cnt_q == IDLE_T) ? IDLE_T : idle_cnt_q + 1'b1;
                active_d   = active_q && (idle_cnt_d != IDLE_T);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_en_q  <= 1'b0;
            fall_en_q  <= 1'b0;
            level_q    <= 1'b0;
            active_q   <= 1'b0;
            idle_cnt_q <= '0;
            rise_cnt_q <= '0;
        end else begin
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            level_q    <= level_d;
            active_q   <= active_d;
            idle_cnt_q <= idle_cnt_d;
            rise_cnt_q <= rise_cnt_d;
        end
    end

    assign rise_en_o    = rise_en_q;
    assign fall_en_o    = fall_en_q;
    assign level_o      = level_q;
    assign clk_active_o = active_q;
    assign rise_count_o = rise_cnt_q;

endmodule

// File: rtl/clock_sync_multi.sv
// Qualifies NUM_CH slow external clocks into one-cycle rise/fall enables on internal_clk.
// Latency: SYNC_STAGES+THRESHOLD cycles from a stable input change to its pulse.
// Backpressure: none; channels run independently every cycle.
module clock_sync_multi
    import clock_sync_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int HIGH_THRESHOLD = DEF_HIGH_THRESHOLD,
    parameter int LOW_THRESHOLD  = DEF_LOW_THRESHOLD,
    parameter int FILT_W         = DEF_FILT_W,
    parameter int IDLE_TIMEOUT   = DEF_IDLE_TIMEOUT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                    internal_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       data_clk,
    output logic [NUM_CH-1:0]       rise_en,
    output logic [NUM_CH-1:0]       fall_en,
    output logic [NUM_CH-1:0]       level,
    output logic [NUM_CH-1:0]       clk_active,
    output logic [NUM_CH*CNT_W-1:0] rise_count
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_sync_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .HIGH_THRESHOLD (HIGH_THRESHOLD),
            .LOW_THRESHOLD  (LOW_THRESHOLD),
            .FILT_W         (FILT_W),
            .IDLE_TIMEOUT   (IDLE_TIMEOUT),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk_i        (internal_clk),
            .rst_i        (reset),
            .enable_i     (enable),
            .data_clk_i   (data_clk[g]),
            .rise_en_o    (rise_en[g]),
            .fall_en_o    (fall_en[g]),
            .level_o      (level[g]),
            .clk_active_o (clk_active[g]),
            .rise_count_o (rise_count[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_clock_sync_multi.sv
// Self-checking bench for clock_sync_multi with a run-length reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_clock_sync_multi;

    localparam int NUM_CH = 2;
    localparam int S      = 2;
    localparam int HT     = 4;
    localparam int LT     = 4;
    localparam int IT     = 10;
    localparam int CW     = 8;
    localparam int MAXN   = 16384;

    logic                    internal_clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic [NUM_CH-1:0]       data_clk;
    logic [NUM_CH-1:0]       rise_en, fall_en, level, clk_active;
    logic [NUM_CH*CW-1:0]    rise_count;

    int errors = 0;
    int checks = 0;

    always #5 internal_clk = ~internal_clk;

    clock_sync_multi #(
        .NUM_CH         (NUM_CH),
        .SYNC_STAGES    (S),
        .HIGH_THRESHOLD (HT),
        .LOW_THRESHOLD  (LT),
        .FILT_W         (5),
        .IDLE_TIMEOUT   (IT),
        .CNT_W          (CW)
    ) dut (
        .internal_clk (internal_clk),
        .reset        (reset),
        .enable       (enable),
        .data_clk     (data_clk),
        .rise_en      (rise_en),
        .fall_en      (fall_en),
        .level        (level),
        .clk_active   (clk_active),
        .rise_count   (rise_count)
    );

    // Reference model: raw sample history, run length of the delayed sample,
    // qualified level (-1 unknown), last edge time and rise tally per channel.
    bit   raw [NUM_CH][MAXN];
    int   n;
    int   m_st [NUM_CH];
    int   m_rv [NUM_CH];
    int   m_rl [NUM_CH];
    bit   m_seen [NUM_CH];
    int   m_last [NUM_CH];
    int   m_cnt [NUM_CH];
    int   sv, thr;
    logic [NUM_CH-1:0]    e_rise, e_fall, e_level, e_active;
    logic [NUM_CH*CW-1:0] e_count;

    always @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            n = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_st[c] = -1; m_rv[c] = 0; m_rl[c] = 0;
                m_seen[c] = 0; m_last[c] = 0; m_cnt[c] = 0;
            end
            e_rise = '0; e_fall = '0; e_level = '0; e_active = '0; e_count = '0;
        end else begin
            n++;
            for (int c = 0; c < NUM_CH; c++) begin
                raw[c][n % MAXN] = data_clk[c];
                sv = (n > S) ? int'(raw[c][(n - S) % MAXN]) : 0;
                e_rise[c] = 1'b0;
                e_fall[c] = 1'b0;
                if (!enable) begin
                    m_st[c] = -1; m_rl[c] = 0; m_seen[c] = 0;
                end else begin
                    if (m_rl[c] > 0 && sv == m_rv[c]) begin
                        if (m_rl[c] < 1000000) m_rl[c]++;
                    end else begin
                        m_rv[c] = sv; m_rl[c] = 1;
                    end
                    thr = (m_rv[c] == 1) ? HT : LT;
                    if (m_rl[c] == thr) begin
                        if (m_st[c] == -1) begin
                            m_st[c] = m_rv[c];
                        end else if (m_st[c] != m_rv[c]) begin
                            if (m_rv[c] == 1) begin
                                e_rise[c] = 1'b1;
                                m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
                            end else begin
                                e_fall[c] = 1'b1;
                            end
                            m_st[c] = m_rv[c];
                            m_seen[c] = 1;
                            m_last[c] = n;
                        end
                    end
                end
                e_level[c]  = (m_st[c] == 1);
                e_active[c] = m_seen[c] && ((n - m_last[c]) < IT);
                e_count[c*CW +: CW] = CW'(m_cnt[c]);
            end
        end
    end

    int pr [NUM_CH];
    int pf [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance k cycles; compare every output with the model at each negedge
    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge internal_clk);
            @(negedge internal_clk);
            chk("m_rise",   32'(rise_en),    32'(e_rise));
            chk("m_fall",   32'(fall_en),    32'(e_fall));
            chk("m_level",  32'(level),      32'(e_level));
            chk("m_active", 32'(clk_active), 32'(e_active));
            chk("m_count",  32'(rise_count), 32'(e_count));
            for (int c = 0; c < NUM_CH; c++) begin
                if (rise_en[c]) pr[c]++;
                if (fall_en[c]) pf[c]++;
            end
        end
    endtask

    task automatic clr_pulses();
        for (int c = 0; c < NUM_CH; c++) begin
            pr[c] = 0; pf[c] = 0;
        end
    endtask

    int at, got, act, hits;

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        data_clk = '0;
        clr_pulses();
        cyc(3);
        chk("reset_rise",   32'(rise_en),    0);
        chk("reset_fall",   32'(fall_en),    0);
        chk("reset_level",  32'(level),      0);
        chk("reset_active", 32'(clk_active), 0);
        chk("reset_count",  32'(rise_count), 0);

        // UNKNOWN -> HIGH on ch0 with no pulse; ch1 qualifies LOW
        reset    = 1'b0;
        enable   = 1'b1;
        data_clk = 2'b01;
        cyc(5);
        chk("unk_level_early", 32'(level[0]), 0);
        cyc(1);
        chk("unk_level", 32'(level[0]), 1);
        chk("unk_no_rise", 32'(rise_en), 0);

        // Drop ch0 to LOW, then one clean rise with the expected latency
        data_clk[0] = 1'b0;
        cyc(10);
        data_clk[0] = 1'b1;
        hits = 0; at = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (rise_en[0]) begin hits++; at = i; end
        end
        chk("rise_once",    32'(hits), 1);
        chk("rise_latency", 32'(at),   6);
        chk("rise_count0",  32'(rise_count[7:0]), 1);

        // 3-sample glitch is rejected, 4-sample low qualifies
        clr_pulses();
        data_clk[0] = 1'b0;
        cyc(3);
        data_clk[0] = 1'b1;
        cyc(15);
        chk("glitch_no_fall", 32'(pf[0]), 0);
        chk("glitch_level",   32'(level[0]), 1);
        clr_pulses();
        data_clk[0] = 1'b0;
        cyc(4);
        data_clk[0] = 1'b1;
        cyc(15);
        chk("short_low_fall", 32'(pf[0]), 1);

        // 256 rises on ch1 wrap its counter; ch0 untouched
        clr_pulses();
        for (int r = 0; r < 256; r++) begin
            data_clk[1] = 1'b1;
            cyc(5);
            data_clk[1] = 1'b0;
            cyc(5);
        end
        cyc(10);
        chk("wrap_rises",  32'(pr[1]), 256);
        chk("wrap_count1", 32'(rise_count[15:8]), 0);
        chk("wrap_count0", 32'(rise_count[7:0]), 2);

        // Simultaneous rises on both channels
        data_clk = 2'b00;
        cyc(10);
        data_clk = 2'b11;
        cyc(5);
        chk("both_not_yet", 32'(rise_en), 0);
        cyc(1);
        chk("both_rise", 32'(rise_en), 2'b11);
        cyc(2);

        // Disable while high: level and activity clear, no pulses while off
        enable = 1'b0;
        cyc(1);
        chk("dis_level",  32'(level), 0);
        chk("dis_active", 32'(clk_active), 0);
        clr_pulses();
        data_clk = 2'b00;
        cyc(8);
        data_clk = 2'b11;
        cyc(8);
        chk("dis_pulses", 32'(pr[0] + pr[1] + pf[0] + pf[1]), 0);

        // Re-enable: UNKNOWN -> HIGH gives no activity; one fall then idle timeout
        enable = 1'b1;
        cyc(8);
        chk("reen_active", 32'(clk_active), 0);
        data_clk[0] = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            cyc(1);
            if (fall_en[0]) got = 1;
        end
        chk("idle_fall_seen", 32'(got), 1);
        act = 0;
        for (int i = 0; i < 15; i++) begin
            if (clk_active[0]) act++;
            cyc(1);
        end
        chk("idle_active_len", 32'(act), IT);
        chk("idle_dropped", 32'(clk_active[0]), 0);

        // Reset mid-operation clears all outputs immediately
        data_clk[0] = 1'b1;
        cyc(7);
        chk("pre_reset_level", 32'(level), 2'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_rise",   32'(rise_en),    0);
        chk("mid_reset_fall",   32'(fall_en),    0);
        chk("mid_reset_level",  32'(level),      0);
        chk("mid_reset_active", 32'(clk_active), 0);
        chk("mid_reset_count",  32'(rise_count), 0);
        cyc(2);
        reset = 1'b0;
        clr_pulses();
        cyc(5);
        chk("post_reset_pulses", 32'(pr[0] + pr[1] + pf[0] + pf[1]), 0);

        // Random toggling with occasional disable windows
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(3) == 0) data_clk[c] = ~data_clk[c];
            end
            if (enable && $urandom_range(199) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(7) == 0) enable = 1'b1;
            cyc(1);
            chk("excl_ch0", 32'(rise_en[0] & fall_en[0]), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
